calc_entry_sequencer: RTL
=========================

// Module: calc_entry_sequencer
// PURPOSE
//  FSM that sequences the calculator: operand A entry, operand B entry, compute handshake, result display.
//  Drives the 2-bit display select consumed by the display mux (00=A, 10=B, 11=answer; 01 never driven).
//  Issues load strobes to the operand registers and a start/done handshake to the BCD arithmetic unit.
//  Sits between the debounced key inputs and the operand/arith/display datapath.
// PARAMETERS
//  TIMEOUT_CYC  default 1024  max cycles in COMPUTE waiting for calc_done before abort to ERROR
//  DWELL_CYC    default 50000000  cycles per display page in auto-cycle mode (AUTO_CYCLE_EN only)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  key_enter    in   1  debounced level; action on rising edge only
//  key_clear    in   1  debounced level; action on rising edge only
//  calc_done    in   1  one-cycle pulse from arith unit: result valid on BCD answer bus
//  disp_sel     out  2  display mux select
//  load_a       out  1  one-cycle strobe: capture operand A
//  load_b       out  1  one-cycle strobe: capture operand B
//  calc_start   out  1  one-cycle strobe: begin computation
//  busy         out  1  high while in COMPUTE
//  err          out  1  high while in ERROR
// BEHAVIOUR
//  Edge detect: registered previous value per key; rise = key & ~key_q. key_q resets to 1 (key held through reset is not an edge).
//  States: ENTER_A, ENTER_B, COMPUTE, SHOW, ERROR. Reset -> ENTER_A; outputs reset to disp_sel=00, all strobes/busy/err 0; timeout counter 0.
//  ENTER_A: disp_sel=00. enter rise -> load_a=1 for one cycle (cycle after edge), go ENTER_B.
//  ENTER_B: disp_sel=10. enter rise -> load_b=1 and calc_start=1 same cycle, go COMPUTE.
//  COMPUTE: disp_sel=10, busy=1. Counter increments each cycle from 0.
//   calc_done -> SHOW (disp_sel=11 next cycle). Counter reaching TIMEOUT_CYC-1 without done -> ERROR.
//   calc_done on the same cycle as counter terminal: done wins -> SHOW.
//   key_enter ignored in COMPUTE.
//  SHOW: disp_sel=11. enter rise -> ENTER_A with load_a=0 (new entry cycle; no strobe).
//  ERROR: disp_sel=11, err=1. Only key_clear exits.
//  key_clear rise in ANY state: next state ENTER_A, counter cleared, no strobes that cycle; clear beats enter when simultaneous.
//  calc_done outside COMPUTE: ignored.
//  All outputs registered; strobes are exactly one cycle wide; at most one of load_a/load_b asserted per cycle.
//  reset mid-COMPUTE: ENTER_A next cycle, busy=0, no calc_start.
// CONFIGURATION
//  AUTO_CYCLE_EN defined: in SHOW, dwell counter rotates disp_sel 11 -> 00 -> 10 -> 11 every DWELL_CYC cycles;
//   entering SHOW restarts rotation at 11 with counter 0; enter/clear behave as above.
//  AUTO_CYCLE_EN undefined: SHOW holds disp_sel=11 permanently; no dwell counter is built.
// TESTING
//  reset held 3 cycles with key_enter=1 -> disp_sel=00, no strobes; release reset, keep enter high -> no load_a.
//  enter edge, enter edge, calc_done 5 cycles after calc_start -> load_a pulse, then load_b+calc_start same cycle,
//   busy for 5 cycles, disp_sel 00->10->11.
//  TIMEOUT_CYC=16, no calc_done -> err=1 after 16 COMPUTE cycles, disp_sel=11; enter edges ignored; clear edge -> ENTER_A, err=0.
//  calc_done on terminal timeout cycle -> SHOW, err stays 0; key_clear and key_enter rise same cycle in ENTER_B -> ENTER_A, no load_b.
//  AUTO_CYCLE_EN, DWELL_CYC=4 in SHOW -> disp_sel 11,00,10,11 changing every 4 cycles; enter edge -> ENTER_A, disp_sel=00.
//  Spurious calc_done in ENTER_A/SHOW -> no state change; reset asserted mid-COMPUTE -> ENTER_A, busy=0 next cycle.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer: sequences operand A/B entry, compute handshake, display.
// Optional macro AUTO_CYCLE_EN rotates the display page while showing result.
module calc_entry_sequencer #(
  parameter int TIMEOUT_CYC = 1024
`ifdef AUTO_CYCLE_EN
  , parameter int DWELL_CYC = 50000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       calc_done,
  output logic [1:0] disp_sel,
  output logic       load_a,
  output logic       load_b,
  output logic       calc_start,
  output logic       busy,
  output logic       err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b10;
  localparam logic [1:0] SEL_ANS = 2'b11;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_COMPUTE,
    S_SHOW,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_enter_q;
  logic          r_clear_q;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_disp_sel;
  logic [1:0]    w_disp_sel_nxt;
  logic          r_load_a;
  logic          r_load_b;
  logic          r_calc_start;
  logic          r_busy;
  logic          r_err;
  logic          w_load_a_nxt;
  logic          w_load_b_nxt;
  logic          w_calc_start_nxt;
  logic          w_enter_rise;
  logic          w_clear_rise;
  logic [1:0]    w_show_sel;

  assign w_enter_rise = key_enter & ~r_enter_q;
  assign w_clear_rise = key_clear & ~r_clear_q;

`ifdef AUTO_CYCLE_EN
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);

  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_nxt;
  logic [1:0]    r_page;
  logic [1:0]    w_page_nxt;
  logic [1:0]    w_page_rot;

  always_comb begin
    w_page_rot = SEL_ANS;
    unique case (r_page)
      SEL_ANS: w_page_rot = SEL_A;
      SEL_A:   w_page_rot = SEL_B;
      default: w_page_rot = SEL_ANS;
    endcase
  end

  // Rotation restarts at the answer page whenever SHOW is (re)entered.
  always_comb begin
    w_dwell_nxt = '0;
    w_page_nxt  = SEL_ANS;
    if (r_state == S_SHOW && w_state_nxt == S_SHOW) begin
      if (r_dwell == DWELL_LAST) begin
        w_page_nxt = w_page_rot;
      end else begin
        w_dwell_nxt = r_dwell + DW'(1);
        w_page_nxt  = r_page;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell <= '0;
      r_page  <= SEL_ANS;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_page  <= w_page_nxt;
    end
  end

  assign w_show_sel = w_page_nxt;
`else
  assign w_show_sel = SEL_ANS;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ENTER_A;
      r_enter_q    <= 1'b1;
      r_clear_q    <= 1'b1;
      r_cnt        <= '0;
      r_disp_sel   <= SEL_A;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_calc_start <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_enter_q    <= key_enter;
      r_clear_q    <= key_clear;
      r_cnt        <= w_cnt_nxt;
      r_disp_sel   <= w_disp_sel_nxt;
      r_load_a     <= w_load_a_nxt;
      r_load_b     <= w_load_b_nxt;
      r_calc_start <= w_calc_start_nxt;
      r_busy       <= (w_state_nxt == S_COMPUTE);
      r_err        <= (w_state_nxt == S_ERROR);
    end
  end

  // Counter stays zero outside COMPUTE; clear has priority over all keys.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = '0;
    w_load_a_nxt     = 1'b0;
    w_load_b_nxt     = 1'b0;
    w_calc_start_nxt = 1'b0;
    if (w_clear_rise) begin
      w_state_nxt = S_ENTER_A;
    end else begin
      unique case (r_state)
        S_ENTER_A: begin
          if (w_enter_rise) begin
            w_state_nxt  = S_ENTER_B;
            w_load_a_nxt = 1'b1;
          end
        end
        S_ENTER_B: begin
          if (w_enter_rise) begin
            w_state_nxt      = S_COMPUTE;
            w_load_b_nxt     = 1'b1;
            w_calc_start_nxt = 1'b1;
          end
        end
        S_COMPUTE: begin
          if (calc_done) begin
            w_state_nxt = S_SHOW;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_SHOW: begin
          if (w_enter_rise) begin
            w_state_nxt = S_ENTER_A;
          end
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_ENTER_A;
        end
      endcase
    end
  end

  always_comb begin
    w_disp_sel_nxt = SEL_A;
    unique case (w_state_nxt)
      S_ENTER_B: w_disp_sel_nxt = SEL_B;
      S_COMPUTE: w_disp_sel_nxt = SEL_B;
      S_SHOW:    w_disp_sel_nxt = w_show_sel;
      S_ERROR:   w_disp_sel_nxt = SEL_ANS;
      default:   w_disp_sel_nxt = SEL_A;
    endcase
  end

  assign disp_sel   = r_disp_sel;
  assign load_a     = r_load_a;
  assign load_b     = r_load_b;
  assign calc_start = r_calc_start;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
